servo_pwm_multi: RTL

Multi-channel servo/motor PWM generator; the parametrised successor to the single-channel, switch-selected PWM block. It runs N independent pulse-width channels off one shared period counter. The counter is advanced by an internal clock-enable prescaler; there is no derived clock. Each channel has a host-writable target width, clamping, and optional per-period slew limiting (ramping). Width changes apply only at period boundaries, so no output pulse is ever truncated. It sits between the control/switch-decode logic and the motor/servo output pins.

---
 rtl/servo_pwm_pkg.sv | 35 +++
 rtl/servo_pwm_multi_tick_gen.sv | 27 ++
 rtl/servo_pwm_multi.sv | 117 +++++++++++
 3 files changed

// File: rtl/servo_pwm_pkg.sv
// Shared constants and width arithmetic for the multi-channel servo PWM block.
package servo_pwm_pkg;

    localparam int unsigned DEF_NUM_CH       = 4;
    localparam int unsigned DEF_CLK_DIV      = 500;
    localparam int unsigned DEF_PERIOD_TICKS = 2000;
    localparam int unsigned DEF_WIDTH_W      = 12;
    localparam int unsigned DEF_MIN_W        = 100;
    localparam int unsigned DEF_MAX_W        = 200;
    localparam int unsigned DEF_RESET_W      = 150;
    localparam int unsigned DEF_STEP_W       = 4;

    // Limit a requested width to the [lo, hi] window.
    function automatic int unsigned clamp_width(input int unsigned v,
                                                input int unsigned lo,
                                                input int unsigned hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    // Move cur toward tgt by at most step; never overshoots and never wraps.
    function automatic int unsigned step_toward(input int unsigned cur,
                                                input int unsigned tgt,
                                                input int unsigned step);
        int unsigned diff;
        if (tgt > cur) begin
            diff = tgt - cur;
            return cur + ((diff < step) ? diff : step);
        end
        diff = cur - tgt;
        return cur - ((diff < step) ? diff : step);
    endfunction

endpackage

// File: rtl/servo_pwm_multi_tick_gen.sv
// Prescaler producing a one-clk tick enable every CLK_DIV clocks.
module pwm_tick_gen #(
    parameter int unsigned CLK_DIV = 500
) (
    input  logic clk,
    input  logic reset_n,
    output logic tick
);

    localparam int unsigned CNT_W = $clog2(CLK_DIV);

    logic [CNT_W-1:0] count;

    assign tick = (count == CNT_W'(CLK_DIV - 1));

    // Free-running divider, wraps to zero on the tick clk.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (tick) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/servo_pwm_multi.sv
// N-channel servo PWM generator sharing one period counter; widths change only
// at period boundaries, with optional per-period slew limiting.
module servo_pwm_multi
    import servo_pwm_pkg::*;
#(
    parameter int unsigned NUM_CH       = DEF_NUM_CH,
    parameter int unsigned CLK_DIV      = DEF_CLK_DIV,
    parameter int unsigned PERIOD_TICKS = DEF_PERIOD_TICKS,
    parameter int unsigned WIDTH_W      = DEF_WIDTH_W,
    parameter int unsigned MIN_W        = DEF_MIN_W,
    parameter int unsigned MAX_W        = DEF_MAX_W,
    parameter int unsigned RESET_W      = DEF_RESET_W,
    parameter int unsigned STEP_W       = DEF_STEP_W
) (
    input  logic                                         clk,
    input  logic                                         reset_n,
    input  logic [NUM_CH-1:0]                            ch_enable,
    input  logic                                         ramp_en,
    input  logic [STEP_W-1:0]                            ramp_step,
    input  logic                                         wr_en,
    input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] wr_ch,
    input  logic [WIDTH_W-1:0]                           wr_data,
    output logic                                         wr_err,
    output logic [NUM_CH-1:0]                            pwm_out,
    output logic                                         period_start,
    output logic                                         busy
);

    localparam int unsigned PER_W = $clog2(PERIOD_TICKS + 1);

    logic               tick;
    logic               boundary;
    logic [PER_W-1:0]   period;
    logic [PER_W-1:0]   period_nxt;
    logic               wr_valid;
    logic               wr_clamped;
    logic [WIDTH_W-1:0] wr_clamp;
    logic [NUM_CH-1:0]  differ;

    pwm_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .tick    (tick)
    );

    // Next period count and boundary detection (the tick that wraps to 1).
    always_comb begin
        boundary   = tick && (period == PER_W'(PERIOD_TICKS));
        period_nxt = period;
        if (boundary) begin
            period_nxt = PER_W'(1);
        end else if (tick) begin
            period_nxt = period + PER_W'(1);
        end
    end

    // Decode of the host write: index check and clamping.
    always_comb begin
        wr_valid   = (32'(wr_ch) < NUM_CH);
        wr_clamp   = WIDTH_W'(clamp_width(32'(wr_data), MIN_W, MAX_W));
        wr_clamped = (wr_clamp != wr_data);
    end

    // Shared period counter, boundary strobe, write error and busy flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            period       <= PER_W'(1);
            period_start <= 1'b0;
            wr_err       <= 1'b0;
            busy         <= 1'b0;
        end else begin
            period       <= period_nxt;
            period_start <= boundary;
            wr_err       <= wr_en && (!wr_valid || wr_clamped);
            busy         <= |differ;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [WIDTH_W-1:0] target_q;
        logic [WIDTH_W-1:0] active_q;
        logic [WIDTH_W-1:0] target_d;
        logic [WIDTH_W-1:0] active_d;
        logic               en_q;
        logic               en_d;
        logic               pwm_q;

        // The boundary consumes target_q, so a write on the boundary clk waits a period.
        assign target_d = (wr_en && wr_valid && (32'(wr_ch) == i)) ? wr_clamp : target_q;
        assign active_d = !boundary ? active_q :
                          ramp_en   ? WIDTH_W'(step_toward(32'(active_q), 32'(target_q),
                                                           32'(ramp_step)))
                                    : target_q;
        assign en_d     = boundary ? ch_enable[i] : en_q;

        assign pwm_out[i] = pwm_q;
        assign differ[i]  = (active_d != target_d);

        // Per-channel width state and registered compare against post-update values.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                target_q <= WIDTH_W'(RESET_W);
                active_q <= WIDTH_W'(RESET_W);
                en_q     <= 1'b0;
                pwm_q    <= 1'b0;
            end else begin
                target_q <= target_d;
                active_q <= active_d;
                en_q     <= en_d;
                pwm_q    <= en_d && (32'(period_nxt) <= 32'(active_d));
            end
        end
    end

endmodule
